seq_capture_check: RTL and testbench
====================================

Name: seq_capture_check

Overview:
Parametrised successor to the single-mode sequence-wait block. It stores up to MAX_LEN colour entries of COLOUR_W bits each. It runs in one of two modes: CAPTURE records player inputs, and VERIFY compares player inputs against the stored pattern. It also has an inactivity timeout. It sits between the debounced button/colour decoder and the game-control FSM, which starts it, reads pass/fail/timeout and reads the stored sequence.

Parameters:
COLOUR_W, 2, bits per colour entry (2 = four colours)
MAX_LEN, 16, maximum number of stored entries
LEN_W, $clog2(MAX_LEN+1), width of the length and index fields
TIMEOUT, 1000, idle cycles allowed between accepted inputs; 0 disables the timeout

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous clear: returns to IDLE and zeroes storage
start  in  1  one-cycle pulse that launches an operation
mode  in  1  0 = CAPTURE, 1 = VERIFY; sampled on start
seq_len  in  LEN_W  number of entries; sampled on start
colour_valid  in  1  one-cycle strobe marking a player entry
colour_val  in  COLOUR_W  colour value, qualified by colour_valid
busy  out  1  high in CAPTURE or VERIFY
done  out  1  high while in DONE
pass  out  1  VERIFY completed with all entries matching
fail  out  1  VERIFY mismatch, or VERIFY timeout
timed_out  out  1  operation ended by the timeout
index  out  LEN_W  count of entries accepted in the current operation
fail_index  out  LEN_W  index of the first mismatching entry
seq_flat  out  MAX_LEN*COLOUR_W  stored sequence; entry i occupies bits [i*COLOUR_W +: COLOUR_W]

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE
  - all outputs 0, storage 0, timeout counter 0
- All outputs are registered and change only on a clk rising edge after reset release.
- States: IDLE, CAPTURE, VERIFY, DONE.
- Start conditions:
  - start is accepted in IDLE or DONE only. It is ignored while busy.
  - On accept: latch len = min(seq_len, MAX_LEN), latch mode; clear index, pass, fail, timed_out, fail_index and the timeout counter.
  - Next state is CAPTURE (mode=0) or VERIFY (mode=1).
  - If len = 0: go directly to DONE. pass = 1 if mode=1; no flags if mode=0.
- A colour_valid arriving in the same cycle as an accepted start is ignored.
- CAPTURE, on each colour_valid:
  - store colour_val at entry[index]; index += 1; reset the timeout counter.
  - When the incremented index equals len: go to DONE the next cycle, with done = 1.
- VERIFY, on each colour_valid, compare colour_val with entry[index]:
  - Match: index += 1 and reset the timeout counter. If the incremented index equals len, go to DONE with pass = 1.
  - Mismatch: go to DONE with fail = 1 and fail_index = index. index is not incremented.
- Timeout:
  - In CAPTURE or VERIFY with TIMEOUT > 0, the counter increments on every cycle without colour_valid.
  - When it reaches TIMEOUT-1 with no input: go to DONE with timed_out = 1. In VERIFY, fail = 1 is also set.
  - colour_valid in that same cycle takes priority; the counter resets instead.
- DONE:
  - Hold done and all flags until start (new operation) or clear.
  - colour_valid is ignored.
- clear: synchronous, highest priority over start and colour_valid. It zeroes storage, all flags and index, and forces IDLE.
- Storage:
  - Entries at or above len are not modified by a CAPTURE.
  - Storage persists across operations, so VERIFY uses the last captured pattern.
  - Entries are never cleared except by rst_n or clear.
- colour_valid held high for N cycles counts as N entries. Debouncing is the upstream block's responsibility.
- seq_len > MAX_LEN is clamped to MAX_LEN.
- busy = state is CAPTURE or VERIFY.
- Outputs and index are valid combinationally from the registered state; there is no extra latency beyond the one-cycle register.

Test Plan:
- Reset mid-CAPTURE after 2 entries: assert rst_n=0 -> immediately busy=0, done=0, index=0, seq_flat=0; after release, state is IDLE.
- CAPTURE, len=4, inputs 2,0,3,1 on separate cycles -> done=1 one cycle after the 4th strobe; seq_flat[7:0]=8'b01_11_00_10; index=4; pass=0, fail=0.
- VERIFY, same pattern, inputs 2,0,3,1 -> done=1, pass=1, fail=0, index=4.
- VERIFY, inputs 2,0,1 -> done=1 after the 3rd strobe; fail=1, fail_index=2, pass=0, index=2.
- VERIFY with TIMEOUT=8: one correct input, then idle -> timed_out=1 and fail=1 exactly 8 cycles after that input; index=1. In CAPTURE the same idle pattern gives timed_out=1, fail=0.
- Edge cases:
  - seq_len=0 in VERIFY -> DONE next cycle with pass=1.
  - seq_len=31 with MAX_LEN=16 -> operation ends after 16 entries.
  - start while busy -> ignored.
  - clear and start in the same cycle -> IDLE with storage zeroed.

Source files
------------

// File: rtl/seq_capture_check_if.sv
// rtl/seq_capture_check_if.sv - control/status bundle between game FSM, colour decoder and seq_capture_check
interface seq_capture_check_if #(
    parameter int COLOUR_W = 2,
    parameter int MAX_LEN  = 16,
    parameter int LEN_W    = $clog2(MAX_LEN + 1)
);
    logic                        clear;
    logic                        start;
    logic                        mode;
    logic [LEN_W-1:0]            seq_len;
    logic                        colour_valid;
    logic [COLOUR_W-1:0]         colour_val;
    logic                        busy;
    logic                        done;
    logic                        pass;
    logic                        fail;
    logic                        timed_out;
    logic [LEN_W-1:0]            index;
    logic [LEN_W-1:0]            fail_index;
    logic [MAX_LEN*COLOUR_W-1:0] seq_flat;

    modport master (
        output clear, start, mode, seq_len, colour_valid, colour_val,
        input  busy, done, pass, fail, timed_out, index, fail_index, seq_flat
    );

    modport slave (
        input  clear, start, mode, seq_len, colour_valid, colour_val,
        output busy, done, pass, fail, timed_out, index, fail_index, seq_flat
    );
endinterface

// File: rtl/seq_capture_check.sv
// rtl/seq_capture_check.sv - colour sequence recorder/verifier with inactivity timeout
module seq_capture_check #(
    parameter int COLOUR_W = 2,
    parameter int MAX_LEN  = 16,
    parameter int LEN_W    = $clog2(MAX_LEN + 1),
    parameter int TIMEOUT  = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_capture_check_if.slave bus
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int SEQ_W = MAX_LEN * COLOUR_W;

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_VERIFY, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    index_q, index_d;
    logic [LEN_W-1:0]    fail_index_q, fail_index_d;
    logic                pass_q, pass_d;
    logic                fail_q, fail_d;
    logic                timed_out_q, timed_out_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [SEQ_W-1:0]    seq_q, seq_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [LEN_W-1:0]    idx_inc;
    logic [LEN_W-1:0]    len_clamp;
    logic [COLOUR_W-1:0] entry;
    logic                timeout_hit;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        index_d      = index_q;
        fail_index_d = fail_index_q;
        pass_d       = pass_q;
        fail_d       = fail_q;
        timed_out_d  = timed_out_q;
        seq_d        = seq_q;
        cnt_d        = cnt_q;

        idx_inc   = index_q + 1'b1;
        len_clamp = (bus.seq_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.seq_len;
        entry     = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LEN_W'(i) == index_q) entry = seq_q[i*COLOUR_W +: COLOUR_W];
        end
        // The idle count compares against TIMEOUT-1 because the cycle that hits it is itself idle.
        timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

        if (bus.clear) begin
            state_d      = S_IDLE;
            seq_d        = '0;
            index_d      = '0;
            fail_index_d = '0;
            pass_d       = 1'b0;
            fail_d       = 1'b0;
            timed_out_d  = 1'b0;
            cnt_d        = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        len_d        = len_clamp;
                        index_d      = '0;
                        fail_index_d = '0;
                        pass_d       = 1'b0;
                        fail_d       = 1'b0;
                        timed_out_d  = 1'b0;
                        cnt_d        = '0;
                        if (len_clamp == '0) begin
                            state_d = S_DONE;
                            pass_d  = bus.mode;
                        end else begin
                            state_d = bus.mode ? S_VERIFY : S_CAPTURE;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (bus.colour_valid) begin
                        for (int i = 0; i < MAX_LEN; i++) begin
                            if (LEN_W'(i) == index_q) seq_d[i*COLOUR_W +: COLOUR_W] = bus.colour_val;
                        end
                        index_d = idx_inc;
                        cnt_d   = '0;
                        if (idx_inc == len_q) state_d = S_DONE;
                    end else if (timeout_hit) begin
                        state_d     = S_DONE;
                        timed_out_d = 1'b1;
                    end else if (TIMEOUT > 0) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_VERIFY: begin
                    if (bus.colour_valid) begin
                        if (bus.colour_val == entry) begin
                            index_d = idx_inc;
                            cnt_d   = '0;
                            if (idx_inc == len_q) begin
                                state_d = S_DONE;
                                pass_d  = 1'b1;
                            end
                        end else begin
                            state_d      = S_DONE;
                            fail_d       = 1'b1;
                            fail_index_d = index_q;
                        end
                    end else if (timeout_hit) begin
                        state_d     = S_DONE;
                        timed_out_d = 1'b1;
                        fail_d      = 1'b1;
                    end else if (TIMEOUT > 0) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d == S_CAPTURE) || (state_d == S_VERIFY);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            index_q      <= '0;
            fail_index_q <= '0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            timed_out_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            seq_q        <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            index_q      <= index_d;
            fail_index_q <= fail_index_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            timed_out_q  <= timed_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            seq_q        <= seq_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.fail       = fail_q;
    assign bus.timed_out  = timed_out_q;
    assign bus.index      = index_q;
    assign bus.fail_index = fail_index_q;
    assign bus.seq_flat   = seq_q;
endmodule

// File: tb/tb_seq_capture_check.sv
// tb/tb_seq_capture_check.sv - directed and randomized bench for seq_capture_check
module tb_seq_capture_check;
    localparam int TOUT = 8;

    logic clk;
    logic rst_n;

    seq_capture_check_if #(.COLOUR_W(2), .MAX_LEN(16)) bus ();

    seq_capture_check #(.COLOUR_W(2), .MAX_LEN(16), .TIMEOUT(TOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    int mem [16];
    int gap [64];
    int val [64];
    int busy_start_edge = -1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_flat();
        logic [31:0] f;
        f = '0;
        for (int i = 0; i < 16; i++) f[i*2 +: 2] = 2'(mem[i]);
        return f;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) mem[i] = 0;
    endtask

    // Plays one operation: start at edge 0, strobe i lands gap[i]+1 edges after the previous one.
    task automatic run_op(input bit m, input int slen, input int n);
        int len, prev, e, got, exp_edge, exp_idx, exp_fi;
        bit exp_pass, exp_fail, exp_to, fin;
        bit sv [512];
        int sc [512];

        len = (slen > 16) ? 16 : slen;
        exp_idx = 0; exp_fi = 0; exp_pass = 0; exp_fail = 0; exp_to = 0;
        exp_edge = 0; prev = 0; fin = 0;
        if (len == 0) begin
            exp_pass = m;
        end else begin
            for (int i = 0; !fin; i++) begin
                if (i >= n || gap[i] >= TOUT) begin
                    exp_edge = prev + TOUT; exp_to = 1; exp_fail = m; exp_idx = i; fin = 1;
                end else begin
                    e = prev + gap[i] + 1;
                    if (!m) begin
                        mem[i] = val[i]; exp_idx = i + 1;
                        if (i + 1 == len) fin = 1;
                    end else if (val[i] != mem[i]) begin
                        exp_fail = 1; exp_fi = i; exp_idx = i; fin = 1;
                    end else begin
                        exp_idx = i + 1;
                        if (i + 1 == len) begin exp_pass = 1; fin = 1; end
                    end
                    if (fin) exp_edge = e;
                    prev = e;
                end
            end
        end

        for (int k = 0; k < 512; k++) begin sv[k] = 0; sc[k] = 0; end
        e = 0;
        for (int i = 0; i < n; i++) begin
            e = e + gap[i] + 1;
            if (e < 512) begin sv[e] = 1; sc[e] = val[i]; end
        end

        bus.start = 1'b1; bus.mode = m; bus.seq_len = 5'(slen); bus.colour_valid = 1'b0;
        step();
        bus.start = 1'b0;
        check("busy_after_start", bus.busy, len > 0);
        got = bus.done ? 0 : -1;
        for (int k = 1; k < 512 && got < 0; k++) begin
            bus.colour_valid = sv[k];
            bus.colour_val   = 2'(sc[k]);
            if (k == busy_start_edge) begin
                bus.start = 1'b1; bus.mode = ~m; bus.seq_len = 5'd2;
            end
            step();
            bus.start = 1'b0;
            bus.colour_valid = 1'b0;
            if (bus.done) got = k;
        end
        check("done_edge", 64'(got), 64'(exp_edge));
        check("busy_end", bus.busy, 1'b0);
        check("index", bus.index, 64'(exp_idx));
        check("pass", bus.pass, exp_pass);
        check("fail", bus.fail, exp_fail);
        check("timed_out", bus.timed_out, exp_to);
        check("fail_index", bus.fail_index, 64'(exp_fi));
        check("seq_flat", bus.seq_flat, model_flat());
    endtask

    initial begin
        int len, n;
        bit m;

        rst_n = 1'b0;
        bus.clear = 1'b0; bus.start = 1'b0; bus.mode = 1'b0;
        bus.seq_len = '0; bus.colour_valid = 1'b0; bus.colour_val = '0;
        clear_model();
        step(); step();
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_flat", bus.seq_flat, 32'h0);
        rst_n = 1'b1;
        step();
        check("idle_done", bus.done, 1'b0);

        // Reset asserted mid-capture after two entries
        bus.start = 1'b1; bus.mode = 1'b0; bus.seq_len = 5'd4;
        step();
        bus.start = 1'b0; bus.colour_valid = 1'b1; bus.colour_val = 2'd2;
        step();
        bus.colour_val = 2'd3;
        step();
        bus.colour_valid = 1'b0;
        check("mid_index", bus.index, 5'd2);
        rst_n = 1'b0;
        #1;
        check("async_busy", bus.busy, 1'b0);
        check("async_done", bus.done, 1'b0);
        check("async_index", bus.index, 5'd0);
        check("async_flat", bus.seq_flat, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_busy", bus.busy, 1'b0);
        check("post_rst_done", bus.done, 1'b0);

        // Capture 2,0,3,1 then verify it
        gap[0] = 0; gap[1] = 0; gap[2] = 0; gap[3] = 0;
        val[0] = 2; val[1] = 0; val[2] = 3; val[3] = 1;
        run_op(0, 4, 4);
        check("flat_lo", bus.seq_flat[7:0], 8'b01_11_00_10);
        run_op(1, 4, 4);
        val[2] = 1;
        run_op(1, 4, 3);

        // Inactivity timeout after one correct entry
        val[0] = 2;
        run_op(1, 4, 1);
        run_op(0, 4, 1);

        run_op(1, 0, 0);

        // Clamp of oversize length
        for (int i = 0; i < 20; i++) begin gap[i] = 0; val[i] = $urandom_range(0, 3); end
        run_op(0, 31, 20);

        // Start pulse while busy must be ignored
        for (int i = 0; i < 4; i++) begin gap[i] = 1; val[i] = $urandom_range(0, 3); end
        busy_start_edge = 3;
        run_op(0, 4, 4);
        busy_start_edge = -1;

        // Clear wins over simultaneous start
        bus.clear = 1'b1; bus.start = 1'b1; bus.mode = 1'b0; bus.seq_len = 5'd4;
        step();
        bus.clear = 1'b0; bus.start = 1'b0;
        clear_model();
        check("clr_busy", bus.busy, 1'b0);
        check("clr_done", bus.done, 1'b0);
        check("clr_flat", bus.seq_flat, 32'h0);
        check("clr_index", bus.index, 5'd0);
        step();
        check("clr_idle", bus.busy, 1'b0);

        for (int op = 0; op < 30; op++) begin
            m = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) len = $urandom_range(0, 31);
            else len = $urandom_range(1, 6);
            n = (len > 16 ? 16 : len) + 1;
            for (int i = 0; i < n; i++) begin
                gap[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(7, 9) : $urandom_range(0, 3);
                if (m && i < 16 && $urandom_range(0, 7) != 0) val[i] = mem[i];
                else val[i] = $urandom_range(0, 3);
            end
            run_op(m, len, n);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
